// File: rtl/spi_slave_core_pkg.sv
// Shared encodings and bit-ordering helpers for the SPI target engine.
package spi_slave_core_pkg;

  typedef logic [1:0] spi_dtb_t;

  localparam spi_dtb_t SPI_TRANS_8_BITS  = 2'd0;
  localparam spi_dtb_t SPI_TRANS_16_BITS = 2'd1;
  localparam spi_dtb_t SPI_TRANS_24_BITS = 2'd2;
  localparam spi_dtb_t SPI_TRANS_32_BITS = 2'd3;

  localparam logic [0:0] SPI_SLV_IDLE   = 1'b0;
  localparam logic [0:0] SPI_SLV_ACTIVE = 1'b1;

  typedef struct packed {
    logic     cpol;
    logic     cpha;
    logic     lsb;
    spi_dtb_t dtb;
  } spi_cfg_t;

  // Index of the last bit of a word: 8*(dtb+1)-1.
  function automatic logic [4:0] last_bit(spi_dtb_t dtb);
    return {dtb, 3'b111};
  endfunction

  // MSB-first words are left-aligned so the next bit is always bit 31.
  function automatic logic [31:0] tx_align(logic [31:0] data, spi_dtb_t dtb, logic lsb);
    logic [4:0] shamt;
    shamt = {~dtb, 3'b000};
    return lsb ? data : (data << shamt);
  endfunction

  function automatic logic tx_head(logic [31:0] sh, logic lsb);
    return lsb ? sh[0] : sh[31];
  endfunction

  function automatic logic [31:0] tx_next(logic [31:0] sh, logic lsb);
    return lsb ? (sh >> 1) : (sh << 1);
  endfunction

  function automatic logic [31:0] rx_insert(logic [31:0] sh, logic din, spi_dtb_t dtb, logic lsb);
    if (lsb) begin
      return (sh >> 1) | ({31'b0, din} << last_bit(dtb));
    end
    return {sh[30:0], din};
  endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// TX/RX word streams between the SPI target engine and its FIFOs or register wrapper.
interface spi_slave_core_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Multi-stage synchroniser for one asynchronous pin, plus a history flop for edge strobes.
module spi_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target engine: oversampled bus front end, word (de)serialiser and RX hold buffer.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpol_i,
  input  logic                    cpha_i,
  input  logic                    lsb_i,
  input  logic [1:0]              dtb_i,
  input  logic                    spi_sck_i,
  input  logic                    spi_nss_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic                    spi_miso_en_o,
  spi_slave_core_if.slave         stream_if,
  output logic                    busy_o,
  output logic                    ovf_o,
  output logic                    udr_o
);

  logic sck_rise, sck_fall, nss_rise, nss_fall, mosi_lvl;
  logic unused_sck_lvl, unused_nss_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i),
    .level_o(unused_sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nss (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_nss_i),
    .level_o(unused_nss_lvl), .rise_o(nss_rise), .fall_o(nss_fall)
  );

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_mosi_i),
    .level_o(mosi_lvl), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  logic [0:0]  state_q, state_d;
  spi_cfg_t    cfg_q, cfg_d, cfg_in, ld_cfg;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic        miso_q, miso_d, rx_valid_q, rx_valid_d, ovf_q, ovf_d;
  logic        lead, trail, sample_stb, shift_stb, tx_load, push;
  logic [31:0] tx_word, rx_word;

  assign cfg_in     = {cpol_i, cpha_i, lsb_i, dtb_i};
  assign lead       = cfg_q.cpol ? sck_fall : sck_rise;
  assign trail      = cfg_q.cpol ? sck_rise : sck_fall;
  assign sample_stb = cfg_q.cpha ? trail : lead;
  assign shift_stb  = cfg_q.cpha ? lead : trail;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    cnt_d      = cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    miso_d     = miso_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    ovf_d      = 1'b0;
    tx_load    = 1'b0;
    push       = 1'b0;
    ld_cfg     = cfg_q;
    tx_word    = '0;
    rx_word    = rx_sh_q;

    case (state_q)
      SPI_SLV_IDLE: begin
        if (nss_fall) begin
          state_d = SPI_SLV_ACTIVE;
          cfg_d   = cfg_in;
          ld_cfg  = cfg_in;
          cnt_d   = '0;
          rx_sh_d = '0;
          tx_load = 1'b1;
        end
      end
      default: begin
        if (shift_stb) begin
          miso_d  = tx_head(tx_sh_q, cfg_q.lsb);
          tx_sh_d = tx_next(tx_sh_q, cfg_q.lsb);
        end
        if (sample_stb) begin
          rx_word = rx_insert(rx_sh_q, mosi_lvl, cfg_q.dtb, cfg_q.lsb);
          if (cnt_q == last_bit(cfg_q.dtb)) begin
            cnt_d   = '0;
            rx_sh_d = '0;
            push    = 1'b1;
            tx_load = ~nss_rise;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            rx_sh_d = rx_word;
          end
        end
        // Frame end wins over any bit activity in the same cycle except the RX push.
        if (nss_rise) begin
          state_d = SPI_SLV_IDLE;
          cnt_d   = '0;
          rx_sh_d = '0;
          tx_sh_d = '0;
          miso_d  = 1'b0;
        end
      end
    endcase

    tx_load = tx_load & ~rst_i;
    if (tx_load) begin
      tx_word = tx_align(stream_if.tx_valid ? stream_if.tx_data : 32'h0, ld_cfg.dtb, ld_cfg.lsb);
      // CPHA=0 must have the first bit on MISO before the first leading edge.
      if ((state_q == SPI_SLV_IDLE) && !ld_cfg.cpha) begin
        miso_d  = tx_head(tx_word, ld_cfg.lsb);
        tx_sh_d = tx_next(tx_word, ld_cfg.lsb);
      end else begin
        tx_sh_d = tx_word;
      end
    end

    if (push) begin
      if (!rx_valid_q || stream_if.rx_ready) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_word;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (stream_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SPI_SLV_IDLE;
      cfg_q      <= '0;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o             = (state_q == SPI_SLV_ACTIVE);
  assign spi_miso_en_o      = busy_o;
  assign spi_miso_o         = miso_q;
  assign ovf_o              = ovf_q;
  assign stream_if.tx_ready = tx_load & stream_if.tx_valid;
  assign udr_o              = tx_load & ~stream_if.tx_valid;
  assign stream_if.rx_valid = rx_valid_q;
  assign stream_if.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a bit-banged SPI master plus TX source and RX sink models.
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [1:0] dtb = 2'd0;
  logic       sck = 1'b0, nss = 1'b1, mosi = 1'b0;
  logic       miso, miso_en, busy, ovf, udr;

  spi_slave_core_if bif ();

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb), .dtb_i(dtb),
    .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_en_o(miso_en), .stream_if(bif),
    .busy_o(busy), .ovf_o(ovf), .udr_o(udr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tx_list [64];
  int          tx_wr = 0, tx_rd = 0;
  logic [31:0] rx_log [64];
  int          rx_n = 0, udr_n = 0, ovf_n = 0;

  // TX source: presents the oldest unpopped word.
  always @(posedge clk) begin
    #1;
    bif.tx_valid = (tx_rd < tx_wr);
    bif.tx_data  = (tx_rd < tx_wr) ? tx_list[tx_rd] : 32'h0;
  end

  always @(negedge clk) begin
    if (bif.tx_ready) tx_rd++;
    if (udr) udr_n++;
    if (ovf) ovf_n++;
    if (bif.rx_valid && bif.rx_ready && rx_n < 64) begin
      rx_log[rx_n] = bif.rx_data;
      rx_n++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic half();
    cyc(8);
  endtask

  task automatic setup(input logic pol, input logic ph, input logic l, input logic [1:0] d);
    cpol = pol; cpha = ph; lsb = l; dtb = d; sck = pol;
    cyc(6);
  endtask

  task automatic push_tx(input logic [31:0] w);
    tx_list[tx_wr] = w;
    tx_wr++;
  endtask

  task automatic start();
    nss = 1'b0;
    cyc(8);
  endtask

  task automatic stop();
    half();
    nss = 1'b1;
    cyc(8);
  endtask

  task automatic xfer(input int nb, input logic [31:0] mw, output logic [31:0] sw);
    sw = '0;
    for (int i = 0; i < nb; i++) begin
      int idx = lsb ? i : nb - 1 - i;
      if (!cpha) begin
        mosi = mw[idx]; half(); sck = ~cpol; sw[idx] = miso; half(); sck = cpol;
      end else begin
        half(); sck = ~cpol; mosi = mw[idx]; half(); sck = cpol; sw[idx] = miso;
      end
    end
  endtask

  typedef struct {
    logic        cpol, cpha, lsb;
    logic [1:0]  dtb;
    logic [31:0] tx, mw, exp_miso, exp_rx;
  } vec_t;

  vec_t vec [6];

  initial begin
    logic [31:0] got, got2;
    int b_rx, b_tx, b_udr, b_ovf;

    vec[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_00A5, 32'h0000_003C, 32'h0000_00A5, 32'h0000_003C};
    vec[1] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_1234, 32'h0000_BEEF, 32'h0000_1234, 32'h0000_BEEF};
    vec[2] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h00C0_FFEE, 32'h00AB_CDEF, 32'h00C0_FFEE, 32'h00AB_CDEF};
    vec[3] = '{1'b0, 1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
    vec[4] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'hCAFE_0081, 32'h0000_0042, 32'h0000_0081, 32'h0000_0042};
    vec[5] = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h8000_0001, 32'hF0F0_0F0F, 32'h8000_0001, 32'hF0F0_0F0F};

    bif.rx_ready = 1'b1;
    cyc(4);
    check("reset_miso", {31'b0, miso}, 0);
    check("reset_miso_en", {31'b0, miso_en}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_rx_valid", {31'b0, bif.rx_valid}, 0);
    check("reset_rx_data", bif.rx_data, 0);
    check("reset_tx_ready", {31'b0, bif.tx_ready}, 0);
    check("reset_ovf", {31'b0, ovf}, 0);
    check("reset_udr", {31'b0, udr}, 0);
    rst = 1'b0;
    cyc(4);

    for (int v = 0; v < 6; v++) begin
      setup(vec[v].cpol, vec[v].cpha, vec[v].lsb, vec[v].dtb);
      push_tx(vec[v].tx);
      cyc(2);
      b_rx = rx_n; b_tx = tx_rd; b_udr = udr_n;
      start();
      check("vec_busy", {31'b0, busy}, 1);
      xfer(8 * (int'(vec[v].dtb) + 1), vec[v].mw, got);
      stop();
      check("vec_miso_word", got, vec[v].exp_miso);
      check("vec_rx_count", rx_n - b_rx, 1);
      check("vec_rx_word", rx_log[b_rx], vec[v].exp_rx);
      check("vec_tx_pops", tx_rd - b_tx, 1);
      check("vec_udr_count", udr_n - b_udr, 1);
      check("vec_busy_end", {30'b0, busy, miso_en}, 0);
    end

    // Back-to-back 8-bit words in mode 1.
    setup(1'b0, 1'b1, 1'b0, 2'd0);
    push_tx(32'h11); push_tx(32'h22);
    cyc(2);
    b_rx = rx_n; b_tx = tx_rd; b_udr = udr_n;
    start();
    xfer(8, 32'h55, got);
    xfer(8, 32'hAA, got2);
    stop();
    check("b2b_miso0", got, 32'h11);
    check("b2b_miso1", got2, 32'h22);
    check("b2b_rx_count", rx_n - b_rx, 2);
    check("b2b_rx0", rx_log[b_rx], 32'h55);
    check("b2b_rx1", rx_log[b_rx+1], 32'hAA);
    check("b2b_tx_pops", tx_rd - b_tx, 2);
    check("b2b_udr", udr_n - b_udr, 1);

    // Overflow: consumer stalled across two words.
    setup(1'b0, 1'b0, 1'b0, 2'd0);
    bif.rx_ready = 1'b0;
    push_tx(32'h0F); push_tx(32'hF0);
    cyc(2);
    b_rx = rx_n; b_ovf = ovf_n;
    start();
    xfer(8, 32'h01, got);
    xfer(8, 32'h02, got2);
    stop();
    check("ovf_miso1", got2, 32'hF0);
    check("ovf_rx_valid", {31'b0, bif.rx_valid}, 1);
    check("ovf_rx_data", bif.rx_data, 32'h01);
    check("ovf_pulses", ovf_n - b_ovf, 1);
    bif.rx_ready = 1'b1;
    cyc(3);
    check("ovf_rx_count", rx_n - b_rx, 1);
    check("ovf_rx_word", rx_log[b_rx], 32'h01);
    check("ovf_rx_valid_clr", {31'b0, bif.rx_valid}, 0);

    // Underrun at frame start, then abort after 5 bits.
    setup(1'b0, 1'b0, 1'b0, 2'd0);
    b_rx = rx_n; b_udr = udr_n;
    start();
    check("udr_pulse", udr_n - b_udr, 1);
    check("udr_miso_en", {31'b0, miso_en}, 1);
    xfer(5, 32'h16, got);
    check("udr_miso_zero", got, 0);
    stop();
    check("abort_rx_count", rx_n - b_rx, 0);
    check("abort_idle", {29'b0, busy, miso_en, miso}, 0);
    check("abort_udr_total", udr_n - b_udr, 1);

    // Reset mid-frame after 3 bits, then a clean frame.
    setup(1'b0, 1'b0, 1'b0, 2'd0);
    push_tx(32'h5A);
    cyc(2);
    b_rx = rx_n;
    start();
    xfer(3, 32'h5, got);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_outputs", {26'b0, busy, miso_en, miso, bif.rx_valid, ovf, udr}, 0);
    check("rst_rx_data", bif.rx_data, 0);
    cyc(10);
    nss = 1'b1;
    cyc(8);
    push_tx(32'h96);
    cyc(2);
    start();
    xfer(8, 32'h69, got);
    stop();
    check("rst_next_miso", got, 32'h96);
    check("rst_rx_count", rx_n - b_rx, 1);
    check("rst_next_rx", rx_log[b_rx], 32'h69);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI target-side engine: the device end of the bus that the existing APB4 SPI master drives. It oversamples SCK/NSS/MOSI in the system clock domain, deserialises MOSI into 8/16/24/32-bit words, and serialises words from a TX stream onto MISO. It uses standard single-bit mode only, with CPOL/CPHA/LSB-first selectable. It sits between SPI pads and a pair of FIFOs, or an APB4 register wrapper built later.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `spi_sck_i`, `spi_nss_i` and `spi_mosi_i`; must be at least 2.
- `clk_i` in 1: system clock. Single clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `cpol_i` in 1: idle SCK level.
- `cpha_i` in 1: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- `lsb_i` in 1: 1 = LSB first.
- `dtb_i` in 2: word length, using the `SPI_TRANS_8/16/24/32_BITS` codes (0..3), giving 8*(dtb_i+1) bits.
- `spi_sck_i`, `spi_nss_i`, `spi_mosi_i` in 1 each: bus inputs, asynchronous. NSS is active-low.
- `spi_miso_o` out 1: serial data out.
- `spi_miso_en_o` out 1: pad output enable; high only while a frame is active.
- `tx_valid_i` in 1, `tx_ready_o` out 1, `tx_data_i` in 32: TX word stream. Data is right-aligned.
- `rx_valid_o` out 1, `rx_ready_i` in 1, `rx_data_o` out 32: RX word stream. Data is right-aligned and zero-extended.
- `busy_o` out 1: a frame is active.
- `ovf_o` out 1: one-cycle pulse when an RX word is dropped.
- `udr_o` out 1: one-cycle pulse when a TX word was needed but `tx_valid_i` was low.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops per input, followed by one history flop that produces rise/fall strobes.
  - Leading edge = the edge leaving the `cpol_i` level; trailing edge = the opposite edge.
  - Sample edge = leading edge if `cpha_i`=0, otherwise trailing edge. Shift edge = the other edge.
- **FSM IDLE → ACTIVE**
  - Trigger: synchronised NSS falling.
  - Latch `cpol_i`, `cpha_i`, `lsb_i` and `dtb_i` into config registers. Changes to these inputs while `busy_o`=1 are ignored.
  - Clear the bit counter (5 bits) and the RX shift register.
  - Perform a TX load (rule below).
- **FSM ACTIVE → IDLE**
  - Trigger: synchronised NSS rising, at any bit position.
  - The partial RX word is discarded; no `rx_valid_o` is raised.
  - A TX word already popped is lost; it is not retried.
  - `spi_miso_en_o` and `spi_miso_o` go to 0.
- **TX load:**
  - If `tx_valid_i`=1: pulse `tx_ready_o` for 1 cycle and copy `tx_data_i` into the TX shift register.
  - Otherwise: load 0 and pulse `udr_o`.
  - Only the low 8*(dtb+1) bits are used. The first bit is bit 0 if `lsb_i`=1, otherwise bit 8*(dtb+1)-1.
- **Sample edge:**
  - Shift `spi_mosi_i` into the RX register: into the MSB end of the word when `lsb_i`=1 (so the first bit received ends up as bit 0), otherwise into the LSB.
  - Increment the bit counter.
  - On the last bit of the word:
    - Counter wraps to 0.
    - The completed RX word is offered on the RX stream, including this last sampled bit.
    - A TX load is performed for the next word.
- **Shift edge:** present the next TX bit on `spi_miso_o`.
  - With `cpha_i`=0, the first bit of the first word is driven directly after the frame-start load.
  - With `cpha_i`=0, the first bit of each following word is driven on the trailing edge of the previous word's last bit.
  - With `cpha_i`=1, every word's first bit goes out on its first leading edge.
- **RX hold buffer:**
  - `rx_valid_o` stays high and `rx_data_o` stays stable until `rx_ready_i`.
  - If a new word completes while `rx_valid_o`=1 and `rx_ready_i`=0: the new word is dropped, the old word is kept, and `ovf_o` pulses.
  - If the consumer accepts the old word in the same cycle a new word completes, the new word replaces it with no overflow.
- **Back-to-back words:** NSS held low streams words indefinitely.

## Timing
- Reset values:
  - FSM = IDLE.
  - `spi_miso_o`, `spi_miso_en_o`, `tx_ready_o`, `rx_valid_o`, `busy_o`, `ovf_o`, `udr_o` = 0.
  - `rx_data_o` = 0.
  - All shift registers, counters and synchronisers = 0, except the NSS synchroniser, which resets to 1.
- Reset mid-frame aborts the frame with no RX push. The frame resumes only after the next NSS fall.
- Edge detect latency: a pin edge is seen `SYNC_STAGES`+1 clk cycles later.
- Clock ratio: SCK high and low phases must each be at least 4 clk cycles, i.e. f_sck ≤ f_clk/8.
- MISO setup: `spi_miso_o` updates exactly 1 cycle after the shift-edge strobe.
  - The master sees MISO change ≤ `SYNC_STAGES`+2 clk cycles after its shift edge.
- `busy_o` rises 1 cycle after the NSS-fall strobe and falls 1 cycle after the NSS-rise strobe.
- `tx_ready_o` pulses in the same cycle as the TX load.
- `rx_valid_o` rises 1 cycle after the last sample-edge strobe.
- NSS rising in the same cycle as the last sample edge: the word completes and is pushed, then the block goes to IDLE without a TX load.

## Structure
- Add to `spi_define.sv`:
  - FSM state encoding: `SPI_SLV_IDLE`=0, `SPI_SLV_ACTIVE`=1.
  - Reuse the existing `SPI_TRANS_*` codes.
- Sub-module `spi_slave_sync`: synchroniser plus edge detector, instantiated once per input with rise/fall outputs. NSS uses reset value 1.
- The core holds the FSM, the 5-bit counter, the TX/RX shift registers and the RX hold buffer.

## Test plan
- Mode 0, 8-bit, MSB first: TX 0xA5 queued, master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; `rx_data_o`=0x0000003C; one `tx_ready_o` pulse.
- Mode 3, 16-bit, LSB first: TX 0x1234, master sends 0xBEEF LSB-first → master receives 0x1234; `rx_data_o`=0xBEEF.
- Back-to-back 8-bit words in mode 1, NSS held low, TX 0x11 then 0x22, master sends 0x55 then 0xAA → two RX words in order; MISO streams 0x11 then 0x22 with no gap.
- Overflow: `rx_ready_i`=0 across two words 0x01 and 0x02 → `rx_data_o` stays 0x01; one `ovf_o` pulse.
- Underrun and abort: `tx_valid_i`=0 at frame start → `udr_o` pulse and MISO all zeros. Then NSS rises after 5 bits → no `rx_valid_o`; `busy_o` falls.
- Reset mid-frame after 3 bits with `rst_i`=1 for 1 cycle → all outputs 0. The next full frame is received correctly.
